multicycle_datapath: RTL and testbench

//  Multicycle MIPS-subset core: datapath and FSM controller sharing one external memory port for

---
 rtl/mips_pkg.sv | 90 +++++++++
 rtl/multicycle_control.sv | 169 ++++++++++++++++
 rtl/multicycle_datapath.sv | 117 +++++++++++
 tb/tb_multicycle_datapath.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS-subset core: opcodes, functs, ALU codes,
// controller states, fault codes and the control word passed from FSM to datapath.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_RTYPE  = 4'd2,
        S_RWB    = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWB  = 4'd6,
        S_MEMWR  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDI   = 4'd9,
        S_LOGI   = 4'd10,
        S_IWB    = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13
    } state_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        BSEL_B       = 2'd0,
        BSEL_SEXT    = 2'd1,
        BSEL_ZEXT    = 2'd2,
        BSEL_SEXT_SH = 2'd3
    } alu_b_e;

    typedef struct packed {
        logic       pc_we;
        pc_src_e    pc_src;
        logic       ir_we;
        logic       mdr_we;
        logic       ab_we;
        logic       aluout_we;
        logic       alu_a_sel;     // 0 = pc, 1 = A
        alu_b_e     alu_b_sel;
        logic [2:0] alu_f;
        logic       rf_we;
        logic       rf_dst_rd;     // 0 = rt, 1 = rd
        logic       rf_from_mdr;   // 0 = ALUOut, 1 = MDR
        logic       addr_from_alu; // 0 = pc, 1 = ALUOut
    } ctrl_t;

    function automatic logic [31:0] alu_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] y;
        case (f)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_SLT: y = {31'b0, $signed(a) < $signed(b)};
            default: y = '0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle controller: one state per instruction phase, Moore memory request outputs,
// sticky halt/fault and a watchdog on memory wait cycles.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned WAIT_CNT_W = 5
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    input  logic       zero,
    output ctrl_t      ctrl,
    output logic       mem_req,
    output logic       mem_we,
    output logic       halted,
    output logic [1:0] fault,
    output state_e     state
);

    state_e                state_q, state_d;
    logic [1:0]            fault_q, fault_d;
    logic [WAIT_CNT_W-1:0] wait_q, wait_d;
    logic                  req_state;

    // Handshake: mem_req, mem_we, mem_addr and mem_wdata are decoded from state and hold
    // while waiting; a transfer completes on any edge with mem_req && mem_ready, and
    // mem_ready without mem_req is ignored.
    always_comb begin
        req_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        mem_req   = req_state && !clear;
        mem_we    = (state_q == S_MEMWR) && !clear;
        halted    = (state_q == S_HALT);
        fault     = fault_q;
        state     = state_q;
    end

    always_comb begin
        state_d        = state_q;
        fault_d        = fault_q;
        wait_d         = '0;
        ctrl           = '0;
        ctrl.alu_f     = ALU_ADD;
        ctrl.pc_src    = PC_SEQ;
        ctrl.alu_b_sel = BSEL_B;
        case (state_q)
            S_FETCH: begin
                ctrl.ir_we = mem_ready;
                ctrl.pc_we = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctrl.ab_we     = 1'b1;
                ctrl.aluout_we = 1'b1;
                ctrl.alu_b_sel = BSEL_SEXT_SH;
                case (opcode)
                    OP_RTYPE:      state_d = S_RTYPE;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BEQ;
                    OP_ADDI:       state_d = S_ADDI;
                    OP_ANDI,
                    OP_ORI:        state_d = S_LOGI;
                    OP_J:          state_d = S_JUMP;
                    default: begin
                        state_d = S_HALT;
                        fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_RTYPE: begin
                ctrl.alu_a_sel = 1'b1;
                ctrl.aluout_we = 1'b1;
                state_d        = S_RWB;
                case (funct)
                    FN_ADD: ctrl.alu_f = ALU_ADD;
                    FN_SUB: ctrl.alu_f = ALU_SUB;
                    FN_AND: ctrl.alu_f = ALU_AND;
                    FN_OR:  ctrl.alu_f = ALU_OR;
                    FN_SLT: ctrl.alu_f = ALU_SLT;
                    default: begin
                        ctrl.aluout_we = 1'b0;
                        state_d        = S_HALT;
                        fault_d        = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_RWB: begin
                ctrl.rf_we     = 1'b1;
                ctrl.rf_dst_rd = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMADR: begin
                ctrl.alu_a_sel = 1'b1;
                ctrl.alu_b_sel = BSEL_SEXT;
                ctrl.aluout_we = 1'b1;
                state_d        = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.addr_from_alu = 1'b1;
                ctrl.mdr_we        = mem_ready;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.rf_we       = 1'b1;
                ctrl.rf_from_mdr = 1'b1;
                state_d          = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.addr_from_alu = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_BEQ: begin
                ctrl.alu_a_sel = 1'b1;
                ctrl.alu_f     = ALU_SUB;
                ctrl.pc_we     = zero;
                ctrl.pc_src    = PC_BRANCH;
                state_d        = S_FETCH;
            end
            S_ADDI: begin
                ctrl.alu_a_sel = 1'b1;
                ctrl.alu_b_sel = BSEL_SEXT;
                ctrl.aluout_we = 1'b1;
                state_d        = S_IWB;
            end
            S_LOGI: begin
                ctrl.alu_a_sel = 1'b1;
                ctrl.alu_b_sel = BSEL_ZEXT;
                ctrl.alu_f     = opcode[0] ? ALU_OR : ALU_AND;
                ctrl.aluout_we = 1'b1;
                state_d        = S_IWB;
            end
            S_IWB: begin
                ctrl.rf_we = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_we  = 1'b1;
                ctrl.pc_src = PC_JUMP;
                state_d     = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase

        // Watchdog overrides whatever the phase decided once the wait budget is spent.
        if (req_state && !mem_ready) begin
            wait_d = wait_q + 1'b1;
            if ((WAIT_LIMIT != 0) && (wait_d == WAIT_CNT_W'(WAIT_LIMIT))) begin
                state_d = S_HALT;
                fault_d = FAULT_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_FETCH;
            fault_q <= FAULT_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core: pc/IR/MDR/A/B/ALUOut, register file and ALU, sequenced
// by multicycle_control over a single shared memory port.
module multicycle_datapath
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned WAIT_CNT_W = 5
) (
    input  logic        clock,
    input  logic        clear,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [31:0] pc,
    output state_e      dbg_state
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, mdr_q, a_q, b_q, aluout_q;
    logic [31:0] rf_q [32];

    ctrl_t       ctrl;
    logic [4:0]  rs, rt, rd, rf_waddr;
    logic [15:0] imm;
    logic [31:0] sext, zext, alu_a, alu_b, alu_y, rf_wdata, rd_a, rd_b;
    logic        zero;

    always_comb begin
        rs   = ir_q[25:21];
        rt   = ir_q[20:16];
        rd   = ir_q[15:11];
        imm  = ir_q[15:0];
        sext = {{16{imm[15]}}, imm};
        zext = {16'b0, imm};
        rd_a = rf_q[rs];
        rd_b = rf_q[rt];

        alu_a = ctrl.alu_a_sel ? a_q : pc_q;
        case (ctrl.alu_b_sel)
            BSEL_B:       alu_b = b_q;
            BSEL_SEXT:    alu_b = sext;
            BSEL_ZEXT:    alu_b = zext;
            BSEL_SEXT_SH: alu_b = {sext[29:0], 2'b00};
            default:      alu_b = b_q;
        endcase
        alu_y = alu_op(ctrl.alu_f, alu_a, alu_b);
        zero  = (alu_y == 32'd0);

        // pc already holds the incremented value by the time BEQ/JUMP execute.
        case (ctrl.pc_src)
            PC_SEQ:    pc_d = pc_q + 32'd4;
            PC_BRANCH: pc_d = aluout_q;
            PC_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
            default:   pc_d = pc_q + 32'd4;
        endcase

        rf_waddr  = ctrl.rf_dst_rd ? rd : rt;
        rf_wdata  = ctrl.rf_from_mdr ? mdr_q : aluout_q;
        mem_addr  = ctrl.addr_from_alu ? aluout_q : pc_q;
        mem_wdata = b_q;
        pc        = pc_q;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            if (ctrl.pc_we)     pc_q     <= pc_d;
            if (ctrl.ir_we)     ir_q     <= mem_rdata;
            if (ctrl.mdr_we)    mdr_q    <= mem_rdata;
            if (ctrl.aluout_we) aluout_q <= alu_y;
            if (ctrl.ab_we) begin
                a_q <= rd_a;
                b_q <= rd_b;
            end
        end
    end

    // Register 0 is never written, so it reads as zero after clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (ctrl.rf_we && (rf_waddr != 5'd0)) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    multicycle_control #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .WAIT_CNT_W (WAIT_CNT_W)
    ) u_control (
        .clock     (clock),
        .clear     (clear),
        .opcode    (ir_q[31:26]),
        .funct     (ir_q[5:0]),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (ctrl),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .halted    (halted),
        .fault     (fault),
        .state     (dbg_state)
    );

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: behavioural memory with configurable wait states
// and a scoreboard of expected memory transfers.
module tb_multicycle_datapath;
    import mips_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] ILLEGAL  = 32'hFC00_0000;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        mem_req, mem_we, halted;
    logic [31:0] mem_addr, mem_wdata, pc;
    logic [31:0] mem_rdata = 32'hDEAD_BEEF;
    logic        mem_ready = 1'b0;
    logic [1:0]  fault;
    state_e      dbg_state;

    logic [31:0] mem [0:1023];
    logic [64:0] exp_q[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    int          lat = 0;
    int          wait_n = 0;
    bit          stall = 1'b0;
    bit          force_rdy = 1'b0;
    bit          pend = 1'b0;
    bit          any_req;
    logic        pend_we;
    logic [31:0] pend_addr, pend_wdata;

    multicycle_datapath #(
        .RESET_PC   (RESET_PC),
        .WAIT_LIMIT (16),
        .WAIT_CNT_W (5)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .fault     (fault),
        .pc        (pc),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [64:0] tx_rd(input logic [31:0] a);
        return {1'b0, a, 32'h0};
    endfunction

    function automatic logic [64:0] tx_wr(input logic [31:0] a, input logic [31:0] d);
        return {1'b1, a, d};
    endfunction

    // Memory responder: ready after lat wait cycles unless stalled; force_rdy raises it blindly.
    always @(negedge clock) begin
        if (force_rdy) mem_ready = 1'b1;
        else           mem_ready = mem_req && !stall && (wait_n >= lat);
        if (mem_req && !mem_ready) wait_n++;
        else                       wait_n = 0;
        if (mem_req && mem_ready && !mem_we) mem_rdata = mem[mem_addr[11:2]];
        else                                 mem_rdata = 32'hDEAD_BEEF;
    end

    // Scoreboard and request-stability monitor.
    always @(posedge clock) begin
        logic [64:0] obs;
        cyc++;
        if (mem_req && mem_ready) begin
            last_acc_cyc = cyc;
            obs = {mem_we, mem_addr, mem_we ? mem_wdata : 32'h0};
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL sb_unexpected: observed access %0h expected none", obs);
            end else begin
                check("sb_access", obs, exp_q.pop_front());
            end
            if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
        end
        if (pend && mem_req) begin
            check("addr_stable", mem_addr, pend_addr);
            check("we_stable", mem_we, pend_we);
            if (pend_we) check("wdata_stable", mem_wdata, pend_wdata);
        end
        pend       = mem_req && !mem_ready;
        pend_addr  = mem_addr;
        pend_we    = mem_we;
        pend_wdata = mem_wdata;
    end

    task automatic hold_clear();
        @(posedge clock); #1;
        clear     = 1'b1;
        stall     = 1'b0;
        force_rdy = 1'b0;
        lat       = 0;
        @(posedge clock); #1;
        exp_q.delete();
        for (int i = 0; i < 1024; i++) mem[i] = ILLEGAL;
    endtask

    task automatic start_run();
        @(posedge clock); #1;
        clear = 1'b0;
        cyc   = 0;
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int n = 0;
        while (halted !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_halt_reached"}, halted, 1'b1);
        check({tag, "_sb_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_pc", pc, RESET_PC);
        check("rst_halted", halted, 1'b0);
        check("rst_fault", fault, 2'b00);
        check("rst_state", dbg_state, S_FETCH);
        check("rst_req", mem_req, 1'b0);

        // 1: addi/addi/add with zero-wait memory, result exported by sw
        hold_clear();
        mem[0] = enc_i(6'b001000, 5'd0, 5'd1, 16'd5);
        mem[1] = enc_i(6'b001000, 5'd0, 5'd2, 16'hFFFD);
        mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        mem[3] = enc_i(6'b101011, 5'd0, 5'd3, 16'h0044);
        exp_q.push_back(tx_rd(32'h00));
        exp_q.push_back(tx_rd(32'h04));
        exp_q.push_back(tx_rd(32'h08));
        exp_q.push_back(tx_rd(32'h0C));
        exp_q.push_back(tx_wr(32'h44, 32'd2));
        exp_q.push_back(tx_rd(32'h10));
        start_run();
        repeat (12) @(posedge clock);
        @(negedge clock);
        check("t1_pc_12cyc", pc, 32'h0C);
        check("t1_state_12cyc", dbg_state, S_FETCH);
        check("t1_addr_12cyc", mem_addr, 32'h0C);
        wait_halt("t1", 200);
        check("t1_fault", fault, 2'b01);
        check("t1_mem44", mem[32'h44 >> 2], 32'd2);
        check("t1_last_fetch_cyc", last_acc_cyc, 17);

        // 2: sw/lw round trip with three wait states per access
        hold_clear();
        lat    = 3;
        mem[0] = enc_i(6'b001000, 5'd0, 5'd1, 16'd5);
        mem[1] = enc_i(6'b101011, 5'd0, 5'd1, 16'h0040);
        mem[2] = enc_i(6'b100011, 5'd0, 5'd4, 16'h0040);
        mem[3] = enc_i(6'b101011, 5'd0, 5'd4, 16'h0048);
        exp_q.push_back(tx_rd(32'h00));
        exp_q.push_back(tx_rd(32'h04));
        exp_q.push_back(tx_wr(32'h40, 32'd5));
        exp_q.push_back(tx_rd(32'h08));
        exp_q.push_back(tx_rd(32'h40));
        exp_q.push_back(tx_rd(32'h0C));
        exp_q.push_back(tx_wr(32'h48, 32'd5));
        exp_q.push_back(tx_rd(32'h10));
        start_run();
        wait_halt("t2", 400);
        check("t2_mem40", mem[32'h40 >> 2], 32'd5);
        check("t2_mem48", mem[32'h48 >> 2], 32'd5);
        check("t2_last_fetch_cyc", last_acc_cyc, 42);

        // 3: beq taken, beq not taken, jump
        hold_clear();
        mem[0]      = enc_i(6'b001000, 5'd0, 5'd1, 16'd7);
        mem[1]      = enc_i(6'b001000, 5'd0, 5'd2, 16'd7);
        mem[2]      = enc_i(6'b001000, 5'd0, 5'd5, 16'd9);
        mem[3]      = enc_r(5'd0, 5'd0, 5'd0, 6'h20);
        mem[4]      = enc_i(6'b000100, 5'd1, 5'd2, 16'd2);
        mem[7]      = enc_i(6'b000100, 5'd1, 5'd5, 16'd5);
        mem[8]      = {6'b000010, 26'h100};
        exp_q.push_back(tx_rd(32'h00));
        exp_q.push_back(tx_rd(32'h04));
        exp_q.push_back(tx_rd(32'h08));
        exp_q.push_back(tx_rd(32'h0C));
        exp_q.push_back(tx_rd(32'h10));
        exp_q.push_back(tx_rd(32'h1C));
        exp_q.push_back(tx_rd(32'h20));
        exp_q.push_back(tx_rd(32'h400));
        start_run();
        wait_halt("t3", 300);
        check("t3_last_fetch_cyc", last_acc_cyc, 26);
        check("t3_pc", pc, 32'h404);

        // 4: illegal opcode halts two cycles after the fetch is accepted
        hold_clear();
        exp_q.push_back(tx_rd(32'h00));
        start_run();
        @(posedge clock);
        @(negedge clock);
        check("t4_halted_c1", halted, 1'b0);
        check("t4_state_c1", dbg_state, S_DECODE);
        @(posedge clock);
        @(negedge clock);
        check("t4_halted_c2", halted, 1'b1);
        check("t4_fault_c2", fault, 2'b01);
        any_req = 1'b0;
        repeat (8) begin
            @(negedge clock);
            any_req |= mem_req;
        end
        check("t4_no_req", any_req, 1'b0);
        check("t4_pc_frozen", pc, 32'h04);
        check("t4_sb_drained", exp_q.size(), 0);
        hold_clear();
        @(negedge clock);
        check("t4_clr_pc", pc, RESET_PC);
        check("t4_clr_halted", halted, 1'b0);
        check("t4_clr_fault", fault, 2'b00);
        check("t4_clr_req", mem_req, 1'b0);

        // 5: memory never ready -> watchdog timeout after 16 wait cycles
        hold_clear();
        stall = 1'b1;
        start_run();
        repeat (15) @(posedge clock);
        @(negedge clock);
        check("t5_halted_15", halted, 1'b0);
        check("t5_req_15", mem_req, 1'b1);
        @(posedge clock);
        @(negedge clock);
        check("t5_halted_16", halted, 1'b1);
        check("t5_fault_16", fault, 2'b10);
        check("t5_req_16", mem_req, 1'b0);
        check("t5_sb_drained", exp_q.size(), 0);

        // 6: clear during a stalled store abandons it
        hold_clear();
        mem[0]             = enc_i(6'b101011, 5'd0, 5'd0, 16'h0060);
        mem[32'h60 >> 2]   = 32'h1234_5678;
        exp_q.push_back(tx_rd(32'h00));
        start_run();
        @(posedge clock); #1;
        stall = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("t6_state_memwr", dbg_state, S_MEMWR);
        check("t6_req_memwr", {mem_req, mem_we}, 2'b11);
        check("t6_addr_memwr", mem_addr, 32'h60);
        @(posedge clock); #1;
        clear     = 1'b1;
        force_rdy = 1'b1;
        @(negedge clock);
        check("t6_req_in_clear", mem_req, 1'b0);
        exp_q.push_back(tx_rd(RESET_PC));
        exp_q.push_back(tx_wr(32'h60, 32'h0));
        exp_q.push_back(tx_rd(RESET_PC + 32'h4));
        @(posedge clock); #1;
        clear     = 1'b0;
        force_rdy = 1'b0;
        stall     = 1'b0;
        cyc       = 0;
        check("t6_no_write", mem[32'h60 >> 2], 32'h1234_5678);
        wait_halt("t6", 200);
        check("t6_rerun_write", mem[32'h60 >> 2], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
